// File: rtl/or_tb_pkg.sv
// Shared types for the OR-gate exerciser: FSM states, vector order, first-fail record.
// No latency or backpressure of its own; pure declarations.
package or_tb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Sweep order {a,b}: 00, 01, 10, 11, packed with vector 0 in the low bits.
  localparam logic [7:0] VEC_ORDER = 8'b11_10_01_00;

  localparam int unsigned SET_W  = 4;
  localparam int unsigned PASS_W = 8;

  typedef struct packed {
    logic vld;
    logic a;
    logic b;
  } fail_vec_t;

  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    return VEC_ORDER[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over increment.
// Latency: count visible one cycle after inc; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/or_gate_exerciser.sv
// Sweeps the 4 input vectors of a 2-input OR gate NUM_PASSES times and scores Y against a|b.
// Latency: SETTLE_CYC+2 cycles per vector; no backpressure, start is ignored while busy.
module or_gate_exerciser
  import or_tb_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_PASSES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a_out,
  output logic             b_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [2:0]       first_fail_vec
);

  state_t            state;
  state_t            state_nxt;
  logic [SET_W-1:0]  settle_cnt;
  logic [1:0]        vec_idx;
  logic [PASS_W-1:0] pass_idx;
  fail_vec_t         ffv;

  logic last_vec;
  logic match;
  logic clr_run;
  logic inc_pass;
  logic inc_fail;

  assign last_vec       = (vec_idx == 2'd3) && (pass_idx == PASS_W'(NUM_PASSES - 1));
  assign match          = (y_in == (a_out | b_out));
  assign first_fail_vec = ffv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nxt = DRIVE;
        DRIVE:      state_nxt = SETTLE;
        SETTLE:     if (settle_cnt == '0) state_nxt = CHECK;
        CHECK:      state_nxt = last_vec ? DONE : DRIVE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Abort freezes the counters, so every strobe is gated by it.
  always_comb begin
    busy     = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    done     = (state == DONE);
    clr_run  = !abort && ((state == IDLE) || (state == DONE)) && start;
    inc_pass = !abort && (state == CHECK) && match;
    inc_fail = !abort && (state == CHECK) && !match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      settle_cnt <= '0;
      vec_idx    <= '0;
      pass_idx   <= '0;
      ffv        <= '0;
    end else if (abort) begin
      a_out <= 1'b0;
      b_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_idx  <= '0;
            pass_idx <= '0;
            ffv      <= '0;
          end
        end
        DRIVE: begin
          {a_out, b_out} <= vec_at(vec_idx);
          settle_cnt     <= SET_W'(SETTLE_CYC - 1);
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        end
        CHECK: begin
          if (!match && !ffv.vld) ffv <= {1'b1, a_out, b_out};
          if (!last_vec) begin
            vec_idx <= vec_idx + 2'd1;
            if (vec_idx == 2'd3) pass_idx <= pass_idx + PASS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_run),
    .inc   (inc_pass),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_run),
    .inc   (inc_fail),
    .cnt   (fail_cnt)
  );

endmodule

// File: tb/tb_or_gate_exerciser.sv
// Bench for or_gate_exerciser: default instance checked every cycle against a timeline model,
// plus NUM_PASSES=100 and SETTLE_CYC=1 instances checked with directed expectations.
module tb_or_gate_exerciser;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance
  logic start0 = 1'b0, abort0 = 1'b0, stuck0 = 1'b0;
  logic a0, b0, y0, busy0, done0;
  logic [7:0] pc0, fc0;
  logic [2:0] ffv0;
  assign y0 = stuck0 ? 1'b0 : (a0 | b0);

  // NUM_PASSES=100 instance
  logic start1 = 1'b0, abort1 = 1'b0;
  logic a1, b1, y1, busy1, done1;
  logic [7:0] pc1, fc1;
  logic [2:0] ffv1;
  assign y1 = a1 | b1;

  // SETTLE_CYC=1 instance
  logic start2 = 1'b0, abort2 = 1'b0;
  logic a2, b2, y2, busy2, done2;
  logic [7:0] pc2, fc2;
  logic [2:0] ffv2;
  assign y2 = a2 | b2;

  or_gate_exerciser u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .a_out(a0), .b_out(b0), .y_in(y0), .busy(busy0), .done(done0),
    .pass_cnt(pc0), .fail_cnt(fc0), .first_fail_vec(ffv0)
  );

  or_gate_exerciser #(.NUM_PASSES(100), .CNT_W(8)) u_np (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a_out(a1), .b_out(b1), .y_in(y1), .busy(busy1), .done(done1),
    .pass_cnt(pc1), .fail_cnt(fc1), .first_fail_vec(ffv1)
  );

  or_gate_exerciser #(.SETTLE_CYC(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .a_out(a2), .b_out(b2), .y_in(y2), .busy(busy2), .done(done2),
    .pass_cnt(pc2), .fail_cnt(fc2), .first_fail_vec(ffv2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model of the default instance: t = clock edges since start was accepted.
  localparam int PER   = 2 + 2;
  localparam int TOTAL = 4 * 1 * PER;
  int m_active, m_done, m_t, m_a, m_b, m_pass, m_fail, m_ffv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_t = 0; m_a = 0; m_b = 0;
      m_pass = 0; m_fail = 0; m_ffv = 0;
    end else if (abort0) begin
      m_active = 0; m_done = 0; m_a = 0; m_b = 0;
    end else if (m_active == 0) begin
      if (start0) begin
        m_active = 1; m_done = 0; m_t = 0;
        m_pass = 0; m_fail = 0; m_ffv = 0;
      end
    end else begin
      m_t++;
      if (m_t % PER == 1) begin
        m_a = (((m_t - 1) / PER) % 4) / 2;
        m_b = (((m_t - 1) / PER) % 4) % 2;
      end
      if (m_t % PER == 0) begin
        if ((stuck0 ? 0 : (m_a | m_b)) == (m_a | m_b)) begin
          if (m_pass < 255) m_pass++;
        end else begin
          if (m_fail < 255) m_fail++;
          if (m_ffv == 0) m_ffv = 4 + 2 * m_a + m_b;
        end
      end
      if (m_t == TOTAL) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy", int'(busy0), m_active);
      check("cyc_done", int'(done0), m_done);
      check("cyc_a", int'(a0), m_a);
      check("cyc_b", int'(b0), m_b);
      check("cyc_pass", int'(pc0), m_pass);
      check("cyc_fail", int'(fc0), m_fail);
      check("cyc_ffv", int'(ffv0), m_ffv);
    end
  end

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Starts a run and counts edges from start acceptance to done; optional start pulse mid-run.
  task automatic run_timed(input int which, input int limit, input int pulse_at, output int cyc);
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
    cyc = 0;
    while (!get_done(which) && cyc < limit) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      set_start(which, (cyc == pulse_at) ? 1'b1 : 1'b0);
    end
    set_start(which, 1'b0);
    check("run_timeout", int'(get_done(which)), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    #1 rst_n = 1'b0;
    #3;
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_ab", int'({a0, b0}), 0);
    check("rst_cnts", int'({pc0, fc0}), 0);
    check("rst_ffv", int'(ffv0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // correct DUT, default parameters
    run_timed(0, 100, -1, cyc);
    check("def_cycles", cyc, 16);
    check("def_pass", int'(pc0), 4);
    check("def_fail", int'(fc0), 0);
    check("def_ffv", int'(ffv0), 0);
    check("model_pass", m_pass, 4);
    repeat (3) @(negedge clk);
    check("def_hold_done", int'(done0), 1);
    check("def_hold_ab", int'({a0, b0}), 3);

    // stuck-at-0 DUT, restarted from DONE
    stuck0 = 1'b1;
    run_timed(0, 100, -1, cyc);
    check("sa0_cycles", cyc, 16);
    check("sa0_pass", int'(pc0), 1);
    check("sa0_fail", int'(fc0), 3);
    check("sa0_ffv", int'(ffv0), 5);
    check("model_ffv", m_ffv, 5);
    stuck0 = 1'b0;

    // abort in SETTLE of vector 2
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("ab_pre_busy", int'(busy0), 1);
    check("ab_pre_ab", int'({a0, b0}), 2);
    abort0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort0 = 1'b0;
    check("ab_busy", int'(busy0), 0);
    check("ab_ab", int'({a0, b0}), 0);
    check("ab_pass", int'(pc0), 2);

    // start and abort together: abort wins
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    check("sa_busy", int'(busy0), 0);
    check("sa_pass", int'(pc0), 2);
    @(negedge clk);
    check("sa_busy2", int'(busy0), 0);

    // reset pulse during CHECK of vector 2 with a failing DUT
    stuck0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("rc_pre_pass", int'(pc0), 1);
    check("rc_pre_fail", int'(fc0), 1);
    check("rc_pre_ffv", int'(ffv0), 5);
    #2 rst_n = 1'b0;
    #1;
    check("rc_busy", int'(busy0), 0);
    check("rc_ab", int'({a0, b0}), 0);
    check("rc_cnts", int'({pc0, fc0}), 0);
    check("rc_ffv", int'(ffv0), 0);
    stuck0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rc_idle", int'(busy0), 0);
    run_timed(0, 100, -1, cyc);
    check("rc_cycles", cyc, 16);
    check("rc_pass", int'(pc0), 4);
    check("rc_fail", int'(fc0), 0);

    // SETTLE_CYC=1 with a start pulse while busy
    run_timed(2, 100, 5, cyc);
    check("s1_cycles", cyc, 12);
    check("s1_pass", int'(pc2), 4);
    check("s1_fail", int'(fc2), 0);

    // 100 passes saturate the 8-bit pass counter
    run_timed(1, 2000, -1, cyc);
    check("np_cycles", cyc, 1600);
    check("np_pass", int'(pc1), 255);
    check("np_fail", int'(fc1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/or_gate_exerciser.md
OR_GATE_EXERCISER -- requirements
Module: or_gate_exerciser

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: cycles between applying a vector and sampling y_in; legal range 1..15.
REQ-002 SHALL have parameter NUM_PASSES, default 1: number of full sweeps of the 4 input vectors; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of the pass and fail counters.
REQ-004 SHALL have one clock and an asynchronous active-low reset; there are no other clocks or resets.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  begin a run; sampled only in IDLE and DONE.
REQ-008 abort  in  1  cancel a run; returns to IDLE.
REQ-009 a_out  out  1  drives the DUT input A.
REQ-010 b_out  out  1  drives the DUT input B.
REQ-011 y_in  in  1  DUT output Y.
REQ-012 busy  out  1  high in DRIVE, SETTLE and CHECK.
REQ-013 done  out  1  high while in DONE.
REQ-014 pass_cnt  out  CNT_W  number of matching checks.
REQ-015 fail_cnt  out  CNT_W  number of mismatching checks.
REQ-016 first_fail_vec  out  3  {valid, a, b} of the first mismatch in the run.

Function
REQ-017 SHALL implement the FSM states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-018 IDLE/DONE + start=1 -> DRIVE next cycle; clears pass_cnt, fail_cnt, first_fail_vec, vector index (0) and pass index (0).
REQ-019 DRIVE (1 cycle): register {a_out,b_out} <= vector index (order 00, 01, 10, 11); load settle counter with SETTLE_CYC-1; go to SETTLE.
REQ-020 SETTLE: decrement each cycle; at 0 go to CHECK; SETTLE_CYC=1 means exactly one SETTLE cycle.
REQ-021 CHECK (1 cycle): expected = a_out | b_out; match -> pass_cnt+1, else fail_cnt+1.
REQ-022 First mismatch of a run: first_fail_vec <= {1,a_out,b_out}; later mismatches do not change it.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 CHECK exit: vector 3 of pass NUM_PASSES-1 -> DONE; else vector index +1 (3 wraps to 0 and pass index +1) -> DRIVE.
REQ-025 Per-vector latency SHALL be SETTLE_CYC+2 cycles; total run = 4*NUM_PASSES*(SETTLE_CYC+2) cycles from start-accept to DONE entry.
REQ-026 DONE: hold done=1, counters and a_out/b_out stable until start or abort.
REQ-027 abort=1 in any state -> IDLE next cycle; a_out=b_out=0; counters hold; abort beats start when both are high.
REQ-028 start while busy SHALL be ignored.
REQ-029 y_in X/unknown is out of scope; y_in is treated as a registered-boundary input sampled only in CHECK.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, a_out=0, b_out=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, first_fail_vec=0, both indices 0.
REQ-031 Reset mid-run SHALL discard the run; after release the block waits in IDLE for start.
REQ-032 Reset deassertion is synchronous to clk at the point of use; the first start is accepted on the first clk edge after release.

Structure
REQ-033 Shared package or_tb_pkg SHALL hold the state enum (IDLE, DRIVE, SETTLE, CHECK, DONE) and the vector-order constant.
REQ-034 SHALL instantiate one sub-module, sat_counter (parameter W; inputs inc and clr), used twice, for pass_cnt and fail_cnt.
REQ-035 The block connects to the OR-gate DUT through the existing intf: a_out->A, b_out->B, y_in<-Y.

Verification
REQ-036 Correct OR DUT, defaults, start pulse -> done after 16 cycles, pass_cnt=4, fail_cnt=0, first_fail_vec=000.
REQ-037 DUT stuck-at-0 output -> pass_cnt=1, fail_cnt=3, first_fail_vec=3'b101 (a=0, b=1).
REQ-038 NUM_PASSES=100, CNT_W=8, correct DUT -> pass_cnt=255 (saturated), fail_cnt=0.
REQ-039 abort asserted during SETTLE of vector 2 -> IDLE next cycle, a_out=b_out=0, pass_cnt=2; start and abort together -> remains IDLE.
REQ-040 rst_n pulsed low during CHECK -> all outputs 0 asynchronously, before the next clk edge; a new start gives a clean 16-cycle run.
REQ-041 SETTLE_CYC=1 -> 12 cycles start-to-done; start during busy has no effect on counts or timing.
